// File: rtl/lbm_collide_pipe.sv
// D2Q9 BGK collision pipeline: one lattice cell per beat through an input register and
// five compute stages, single-enable valid/ready flow control, bounce-back for wall cells.
module lbm_collide_pipe #(
  parameter int W      = 16,
  parameter int FRAC   = 14,
  parameter int GUARD  = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [9*W-1:0] f_in,
  input  logic           wall,
  input  logic [W-1:0]   omega,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [9*W-1:0] f_out,
  output logic [W-1:0]   rho_out,
  output logic [W-1:0]   usq_out,
  output logic           sat_flag
);
  localparam int IW = W + GUARD;
  localparam int PW = 2 * IW;
  localparam int XW = IW + 4;
  typedef logic signed [IW-1:0] iw_t;
  typedef logic signed [XW-1:0] xw_t;
  typedef logic signed [PW-1:0] pw_t;

  localparam iw_t MAXV = iw_t'(2**(W-1) - 1);
  localparam iw_t MINV = ~MAXV;
  localparam pw_t HALF = pw_t'(2**(FRAC-1));
  localparam iw_t WT1  = iw_t'((2 * 2**FRAC + 9) / 18);
  localparam iw_t WT5  = iw_t'((2 * 2**FRAC + 36) / 72);
  localparam xw_t K1   = xw_t'(1);
  localparam xw_t K3   = xw_t'(3);
  localparam xw_t K9   = xw_t'(9);

  function automatic iw_t fget(input logic [9*W-1:0] v, input int i);
    return iw_t'($signed(v[i*W +: W]));
  endfunction

  function automatic iw_t rnd_mul(input iw_t a, input iw_t b);
    pw_t p;
    p = pw_t'(a) * pw_t'(b) + HALF;
    return iw_t'(p >>> FRAC);
  endfunction

  // rho + 3eu + 4.5eu^2 - 1.5uu, the half-integer part rounded half-up; headroom for 9*eu^2.
  function automatic iw_t bracket(input iw_t rho, input iw_t eu, input iw_t eu2, input iw_t usq);
    xw_t t;
    t = xw_t'(rho) + K3 * xw_t'(eu) + ((K9 * xw_t'(eu2) - K3 * xw_t'(usq) + K1) >>> 1);
    return iw_t'(t);
  endfunction

  // Returns {clamped, value}; wraps when saturation is disabled.
  function automatic logic [W:0] narrow(input iw_t x);
    if (SAT_EN && x > MAXV) return {1'b1, MAXV[W-1:0]};
    if (SAT_EN && x < MINV) return {1'b1, MINV[W-1:0]};
    return {1'b0, x[W-1:0]};
  endfunction

  function automatic logic [W:0] relax(input iw_t fi, input iw_t feq, input iw_t om);
    return narrow(fi + rnd_mul(om, feq - fi));
  endfunction

  logic           adv;
  logic           s0_v, s1_v, s2_v, s3_v, s4_v;
  logic [9*W-1:0] s0_f, s1_f, s2_f, s3_f, s4_f;
  logic           s0_w, s1_w, s2_w, s3_w, s4_w;
  logic [W-1:0]   s0_om, s1_om, s2_om, s3_om, s4_om;
  iw_t            s1_rho, s2_rho, s3_rho, s4_rho;
  iw_t            s1_jx, s1_jy;
  iw_t            s2_ux, s2_uy, s2_ux2, s2_uy2, s2_uxy;
  iw_t            s3_usq, s4_usq;
  iw_t            s3_eu [1:8];
  iw_t            s3_eu2 [1:8];
  iw_t            s4_feq [1:8];
  iw_t            c_rho, c_jx, c_jy, om_ext, sum8;
  iw_t            c_eu [1:8];
  iw_t            c_eu2 [1:8];
  iw_t            c_feq [1:8];
  logic [9*W-1:0] c_f;
  logic [W:0]     nrw, nusq;
  logic           c_sat;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;
  assign om_ext   = iw_t'({{GUARD{1'b0}}, s4_om});

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    c_rho = '0;
    for (int i = 0; i < 9; i++) c_rho = c_rho + fget(s0_f, i);
    c_jx = fget(s0_f, 1) + fget(s0_f, 6) + fget(s0_f, 7) - fget(s0_f, 2) - fget(s0_f, 5) - fget(s0_f, 8);
    c_jy = fget(s0_f, 4) + fget(s0_f, 6) + fget(s0_f, 8) - fget(s0_f, 3) - fget(s0_f, 5) - fget(s0_f, 7);
  end

  // Diagonal squares come from the shared S2 products: (ux +- uy)^2 = ux^2 + uy^2 +- 2uxuy.
  always_comb begin
    for (int i = 1; i < 9; i++) begin
      c_eu[i]  = '0;
      c_eu2[i] = '0;
      case (i)
        1: begin c_eu[i] = s2_ux;           c_eu2[i] = s2_ux2; end
        2: begin c_eu[i] = -s2_ux;          c_eu2[i] = s2_ux2; end
        3: begin c_eu[i] = -s2_uy;          c_eu2[i] = s2_uy2; end
        4: begin c_eu[i] = s2_uy;           c_eu2[i] = s2_uy2; end
        5: begin c_eu[i] = -(s2_ux + s2_uy); c_eu2[i] = s2_ux2 + s2_uy2 + (s2_uxy <<< 1); end
        6: begin c_eu[i] = s2_ux + s2_uy;    c_eu2[i] = s2_ux2 + s2_uy2 + (s2_uxy <<< 1); end
        7: begin c_eu[i] = s2_ux - s2_uy;    c_eu2[i] = s2_ux2 + s2_uy2 - (s2_uxy <<< 1); end
        default: begin c_eu[i] = s2_uy - s2_ux; c_eu2[i] = s2_ux2 + s2_uy2 - (s2_uxy <<< 1); end
      endcase
    end
  end

  always_comb begin
    for (int i = 1; i < 9; i++)
      c_feq[i] = rnd_mul((i < 5) ? WT1 : WT5, bracket(s3_rho, s3_eu[i], s3_eu2[i], s3_usq));
  end

  // f0 is rebuilt from the clamped f1..f8 so the cell conserves mass exactly.
  always_comb begin
    c_f   = '0;
    c_sat = 1'b0;
    sum8  = '0;
    nrw   = '0;
    for (int i = 1; i < 9; i++) begin
      nrw = relax(fget(s4_f, i), s4_feq[i], om_ext);
      c_f[i*W +: W] = nrw[W-1:0];
      c_sat = c_sat | nrw[W];
      sum8  = sum8 + iw_t'($signed(nrw[W-1:0]));
    end
    nrw = narrow(s4_rho - sum8);
    c_f[0 +: W] = nrw[W-1:0];
    nusq  = narrow(s4_usq);
    c_sat = c_sat | nrw[W] | nusq[W];
    if (s4_w) begin
      c_f   = {s4_f[7*W +: W], s4_f[8*W +: W], s4_f[5*W +: W], s4_f[6*W +: W],
               s4_f[3*W +: W], s4_f[4*W +: W], s4_f[1*W +: W], s4_f[2*W +: W], s4_f[0 +: W]};
      c_sat = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {s0_v, s1_v, s2_v, s3_v, s4_v, out_valid} <= '0;
    end else if (adv) begin
      s0_v      <= in_valid;
      s1_v      <= s0_v;
      s2_v      <= s1_v;
      s3_v      <= s2_v;
      s4_v      <= s3_v;
      out_valid <= s4_v;
    end
  end

  // NOTE: datapath registers carry no reset; each loads only behind its own valid bit.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s0_f <= f_in; s0_w <= wall; s0_om <= omega;
    end
    if (adv && s0_v) begin
      s1_f <= s0_f; s1_w <= s0_w; s1_om <= s0_om;
      s1_rho <= c_rho; s1_jx <= c_jx; s1_jy <= c_jy;
    end
    if (adv && s1_v) begin
      s2_f <= s1_f; s2_w <= s1_w; s2_om <= s1_om; s2_rho <= s1_rho;
      s2_ux  <= s1_jx;
      s2_uy  <= s1_jy;
      s2_ux2 <= rnd_mul(s1_jx, s1_jx);
      s2_uy2 <= rnd_mul(s1_jy, s1_jy);
      s2_uxy <= rnd_mul(s1_jx, s1_jy);
    end
    if (adv && s2_v) begin
      s3_f <= s2_f; s3_w <= s2_w; s3_om <= s2_om; s3_rho <= s2_rho;
      s3_usq <= s2_ux2 + s2_uy2;
      for (int i = 1; i < 9; i++) begin
        s3_eu[i]  <= c_eu[i];
        s3_eu2[i] <= c_eu2[i];
      end
    end
    if (adv && s3_v) begin
      s4_f <= s3_f; s4_w <= s3_w; s4_om <= s3_om; s4_rho <= s3_rho; s4_usq <= s3_usq;
      for (int i = 1; i < 9; i++) s4_feq[i] <= c_feq[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_out    <= '0;
      rho_out  <= '0;
      usq_out  <= '0;
      sat_flag <= 1'b0;
    end else if (adv && s4_v) begin
      f_out    <= c_f;
      rho_out  <= s4_rho[W-1:0];
      usq_out  <= nusq[W-1:0];
      sat_flag <= c_sat;
    end
  end
endmodule

// File: tb/tb_lbm_collide_pipe.sv
// Directed bench for lbm_collide_pipe: rest cell, omega=0, wall, saturation,
// back-to-back stream with a downstream stall, and reset with beats in flight.
module tb_lbm_collide_pipe;
  localparam int W  = 16;
  localparam int FW = 9 * W;

  logic          clk, reset, in_valid, in_ready, wall, out_valid, out_ready, sat_flag;
  logic [FW-1:0] f_in, f_out;
  logic [W-1:0]  omega, rho_out, usq_out;
  int            n_cmp, n_bad;

  typedef struct {
    logic [FW-1:0] f;
    logic [W-1:0]  rho;
    logic [W-1:0]  usq;
  } beat_t;

  lbm_collide_pipe #(.W(16), .FRAC(14), .GUARD(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .f_in(f_in),
    .wall(wall), .omega(omega), .out_valid(out_valid), .out_ready(out_ready),
    .f_out(f_out), .rho_out(rho_out), .usq_out(usq_out), .sat_flag(sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] pack9(input int v [9]);
    logic [FW-1:0] p;
    for (int i = 0; i < 9; i++) p[i*W +: W] = W'(v[i]);
    return p;
  endfunction

  function automatic logic [FW-1:0] swap_pairs(input logic [FW-1:0] f);
    int m [9];
    logic [FW-1:0] p;
    m = '{0, 2, 1, 4, 3, 6, 5, 8, 7};
    for (int i = 0; i < 9; i++) p[i*W +: W] = f[m[i]*W +: W];
    return p;
  endfunction

  function automatic logic [W-1:0] model_rho(input logic [FW-1:0] f);
    longint s;
    s = 0;
    for (int i = 0; i < 9; i++) s = s + longint'($signed(f[i*W +: W]));
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_usq(input logic [FW-1:0] f);
    longint v [9];
    longint jx, jy, s;
    for (int i = 0; i < 9; i++) v[i] = longint'($signed(f[i*W +: W]));
    jx = v[1] + v[6] + v[7] - v[2] - v[5] - v[8];
    jy = v[4] + v[6] + v[8] - v[3] - v[5] - v[7];
    s  = ((jx * jx + 8192) >>> 14) + ((jy * jy + 8192) >>> 14);
    if (s > 32767) s = 32767;
    return s[W-1:0];
  endfunction

  // One beat into an idle pipe; lat counts rising edges after the accepting edge.
  task automatic run_beat(input logic [FW-1:0] f, input logic w, input logic [W-1:0] om, output int lat);
    @(negedge clk);
    f_in = f; wall = w; omega = om; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; wall = 1'b0; omega = '0; f_in = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++;
    if ({f_out, rho_out, usq_out, sat_flag} !== '0) begin
      n_bad++; $display("FAIL reset_fields: got f=%h rho=%h usq=%h sat=%b want all 0", f_out, rho_out, usq_out, sat_flag);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rest_cell();
    int a [9];
    int lat;
    logic [FW-1:0] fv;
    a  = '{7282, 1820, 1820, 1820, 1820, 455, 455, 455, 455};
    fv = pack9(a);
    run_beat(fv, 1'b0, 16'd16384, lat);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL rest_latency: got %0d want 5", lat); end
    n_cmp++;
    if (f_out !== fv) begin n_bad++; $display("FAIL rest_f: got %h want %h", f_out, fv); end
    n_cmp++;
    if ({rho_out, usq_out, sat_flag} !== {16'd16382, 16'd0, 1'b0}) begin
      n_bad++; $display("FAIL rest_rho_usq_sat: got %0d %0d %b want 16382 0 0", rho_out, usq_out, sat_flag);
    end
  endtask

  task automatic test_omega_zero();
    int a [9];
    int lat;
    logic [FW-1:0] fv;
    a  = '{1000, 3000, 500, 800, 1200, 400, 900, 700, 600};
    fv = pack9(a);
    run_beat(fv, 1'b0, 16'd0, lat);
    n_cmp++;
    if (f_out !== fv) begin n_bad++; $display("FAIL omega0_f: got %h want %h", f_out, fv); end
    n_cmp++;
    if ({rho_out, usq_out, sat_flag} !== {16'd9100, 16'd626, 1'b0}) begin
      n_bad++; $display("FAIL omega0_rho_usq_sat: got %0d %0d %b want 9100 626 0", rho_out, usq_out, sat_flag);
    end
  endtask

  task automatic test_wall();
    int a [9];
    int e [9];
    int lat;
    logic [FW-1:0] ev;
    a  = '{0, 100, 200, 300, 400, 500, 600, 700, 800};
    e  = '{0, 200, 100, 400, 300, 600, 500, 800, 700};
    ev = pack9(e);
    run_beat(pack9(a), 1'b1, 16'd16384, lat);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL wall_latency: got %0d want 5", lat); end
    n_cmp++;
    if (f_out !== ev) begin n_bad++; $display("FAIL wall_f: got %h want %h", f_out, ev); end
    n_cmp++;
    if ({rho_out, usq_out, sat_flag} !== {16'd3600, 16'd6, 1'b0}) begin
      n_bad++; $display("FAIL wall_rho_usq_sat: got %0d %0d %b want 3600 6 0", rho_out, usq_out, sat_flag);
    end
  endtask

  task automatic test_saturation();
    int a [9];
    int lat;
    a = '{0, 32767, 0, 0, 0, 0, 0, 0, 0};
    run_beat(pack9(a), 1'b0, 16'd16384, lat);
    n_cmp++;
    if (f_out[W +: W] !== 16'd32767) begin n_bad++; $display("FAIL sat_f1: got %0d want 32767", f_out[W +: W]); end
    n_cmp++;
    if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
    n_cmp++;
    if ({rho_out, usq_out} !== {16'd32767, 16'd32767}) begin
      n_bad++; $display("FAIL sat_rho_usq: got %0d %0d want 32767 32767", rho_out, usq_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] bf [20];
    logic          bw [20];
    logic [W-1:0]  bo [20];
    beat_t q [$];
    beat_t e, held;
    bit    hold_prev;
    int    sent, got, cyc;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 9; k++) bf[i][k*W +: W] = W'($urandom_range(0, 2000));
      bw[i] = (i % 3 == 1);
      bo[i] = bw[i] ? W'($urandom_range(0, 32768)) : '0;
    end
    hold_prev = 1'b0; sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      out_ready = !(cyc >= 12 && cyc < 22);
      if (sent < 20) begin
        in_valid = 1'b1; f_in = bf[sent]; wall = bw[sent]; omega = bo[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_prev) begin
        n_cmp++;
        if ({out_valid, f_out, rho_out, usq_out} !== {1'b1, held.f, held.rho, held.usq}) begin
          n_bad++; $display("FAIL stall_hold: got v=%b f=%h rho=%h usq=%h want v=1 f=%h rho=%h usq=%h",
                            out_valid, f_out, rho_out, usq_out, held.f, held.rho, held.usq);
        end
      end
      hold_prev = 1'b0;
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready, cyc); end
        held.f = f_out; held.rho = rho_out; held.usq = usq_out;
        hold_prev = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got unexpected beat f=%h want none", f_out);
        end else begin
          e = q.pop_front();
          if ({f_out, rho_out, usq_out, sat_flag} !== {e.f, e.rho, e.usq, 1'b0}) begin
            n_bad++; $display("FAIL stream_beat%0d: got f=%h rho=%h usq=%h sat=%b want f=%h rho=%h usq=%h sat=0",
                              got, f_out, rho_out, usq_out, sat_flag, e.f, e.rho, e.usq);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e.f   = bw[sent] ? swap_pairs(bf[sent]) : bf[sent];
        e.rho = model_rho(bf[sent]);
        e.usq = model_usq(bf[sent]);
        q.push_back(e);
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== 20) begin n_bad++; $display("FAIL stream_count: got %0d beats want 20", got); end
  endtask

  task automatic test_reset_midstream();
    int  a [9];
    bit  seen;
    a = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    @(negedge clk);
    out_ready = 1'b0; wall = 1'b0; omega = 16'd8192;
    for (int i = 0; i < 3; i++) begin
      a[1] = 100 * (i + 1);
      f_in = pack9(a); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_preload: got out_valid=%b want 1", out_valid); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, f_out, rho_out, usq_out, sat_flag} !== '0) begin
      n_bad++; $display("FAIL midrst_async: got v=%b f=%h rho=%h usq=%h sat=%b want all 0",
                        out_valid, f_out, rho_out, usq_out, sat_flag);
    end
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got a stale beat after reset want none"); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_rest_cell();
    test_omega_zero();
    test_wall();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
